// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative RV32M multiply/divide unit with start/busy/done handshake,
// result tag and branch-flush kill; one product/quotient bit per CALC cycle.
module riscv_muldiv #(
   parameter int XLEN = 32,
   parameter int TAGW = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [TAGW-1:0] tag_in,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [TAGW-1:0] tag_out
);
   localparam int CW = $clog2(XLEN + 1);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_n;
   logic [2:0] op;
   logic [TAGW-1:0] tag;
   logic sa, sb, a_sgn, b_sgn, sa_in, sb_in, ovf, fast, accept, last;
   logic [CW-1:0] cnt;
   logic [XLEN-1:0] opnd, hi, lo, hi_n, lo_n, ma, mb, fast_res, fin_res, quo, rem;
   logic [XLEN:0] sum, shl, diff;
   logic [2*XLEN-1:0] prod;
   always_comb begin
      a_sgn = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
      b_sgn = funct3[2] ? !funct3[0] : !funct3[1];
      sa_in = a_sgn & a[XLEN-1];
      sb_in = b_sgn & b[XLEN-1];
      ma = sa_in ? -a : a;
      mb = sb_in ? -b : b;
      ovf = !funct3[0] && a == {1'b1, {(XLEN-1){1'b0}}} && &b;
      fast = funct3[2] && (b == '0 || ovf);
      fast_res = (b == '0) ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
      accept = state == IDLE && start && !kill;
      last = state == CALC && cnt == CW'(1);
      // multiply: conditional add then shift right; divide: shift left then trial subtract
      sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      shl = {hi, lo[XLEN-1]};
      diff = shl - {1'b0, opnd};
      hi_n = op[2] ? (diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
      lo_n = op[2] ? {lo[XLEN-2:0], !diff[XLEN]} : {sum[0], lo[XLEN-1:1]};
      prod = (sa ^ sb) ? -{hi_n, lo_n} : {hi_n, lo_n};
      quo = (sa ^ sb) ? -lo_n : lo_n;
      rem = sa ? -hi_n : hi_n;
      fin_res = op[2] ? (op[1] ? rem : quo) : (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
   end
   always_comb begin
      state_n = state;
      if (state == IDLE) state_n = accept ? (fast ? DONE : CALC) : IDLE;
      else if (kill || state != CALC) state_n = IDLE;
      else if (last) state_n = DONE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   assign busy = state != IDLE;
   assign done = state == DONE;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         op <= '0;
         tag <= '0;
         sa <= 1'b0;
         sb <= 1'b0;
         opnd <= '0;
         hi <= '0;
         lo <= '0;
         cnt <= '0;
         result <= '0;
         tag_out <= '0;
      end else if (accept) begin
         op <= funct3;
         tag <= tag_in;
         sa <= sa_in;
         sb <= sb_in;
         opnd <= funct3[2] ? mb : ma;
         lo <= funct3[2] ? ma : mb;
         hi <= '0;
         cnt <= CW'(XLEN);
         if (fast) begin
            result <= fast_res;
            tag_out <= tag_in;
         end
      end else if (state == CALC && !kill) begin
         hi <= hi_n;
         lo <= lo_n;
         cnt <= cnt - CW'(1);
         if (last) begin
            result <= fin_res;
            tag_out <= tag;
         end
      end
endmodule

// File: tb/tb_riscv_muldiv.sv
// tb_riscv_muldiv: scoreboard bench; expected result/tag queued at issue, popped on done.
module tb_riscv_muldiv;
   localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
   localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, kill = 1'b0;
   logic [2:0] funct3 = '0;
   logic [31:0] a = '0, b = '0;
   logic [4:0] tag_in = '0;
   logic busy, done;
   logic [31:0] result, prev;
   logic [4:0] tag_out;
   logic [36:0] exp_q[$];
   logic [36:0] e;
   int n_cmp = 0, n_bad = 0, cyc = 0, t0, n;

   riscv_muldiv #(.XLEN(32), .TAGW(5)) dut (
      .clk(clk), .reset(reset), .start(start), .funct3(funct3), .a(a), .b(b),
      .tag_in(tag_in), .kill(kill), .busy(busy), .done(done), .result(result), .tag_out(tag_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tg, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tg, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] xs, xu, ys, yu, p;
      logic signed [31:0] sx, sy;
      logic ovf;
      xs = {{32{x[31]}}, x};
      ys = {{32{y[31]}}, y};
      xu = {32'b0, x};
      yu = {32'b0, y};
      sx = x;
      sy = y;
      ovf = x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
      p = f == MULH ? xs * ys : f == MULHSU ? xs * yu : xu * yu;
      case (f)
         MUL: return p[31:0];
         MULH, MULHSU, MULHU: return p[63:32];
         DIV: return y == 0 ? 32'hFFFF_FFFF : ovf ? x : 32'(sx / sy);
         DIVU: return y == 0 ? 32'hFFFF_FFFF : x / y;
         REM: return y == 0 ? x : ovf ? 32'h0 : 32'(sx % sy);
         default: return y == 0 ? x : x % y;
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      return (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) ? 1 : 33;
   endfunction

   always @(negedge clk)
      if (done) begin
         if (exp_q.size() == 0) check("spurious_done", {31'b0, done}, 32'h0);
         else begin
            e = exp_q.pop_front();
            check("result", result, e[36:5]);
            check("tag", {27'b0, tag_out}, {27'b0, e[4:0]});
         end
      end

   // called at a negedge with the unit idle; leaves the bench one negedge later
   task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] t, input bit keep, output int ts);
      funct3 = f;
      a = x;
      b = y;
      tag_in = t;
      start = 1'b1;
      ts = cyc;
      if (keep) exp_q.push_back({ref_op(f, x, y), t});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int ts, input int lat);
      int k = 0;
      while (!done && k < 60) begin
         @(negedge clk);
         k++;
      end
      check({nm, "_lat"}, 32'(cyc - ts), 32'(lat));
      @(negedge clk);
      check({nm, "_idle"}, {31'b0, busy}, 32'h0);
   endtask

   task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] t);
      int ts;
      @(negedge clk);
      issue(f, x, y, t, 1'b1, ts);
      wait_done(nm, ts, lat_of(f, x, y));
   endtask

   initial begin
      @(negedge clk);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_done", {31'b0, done}, 32'h0);
      check("rst_result", result, 32'h0);
      check("rst_tag", {27'b0, tag_out}, 32'h0);
      reset = 1'b0;
      run_op("mul", MUL, 32'd7, 32'hFFFF_FFFD, 5'd17);
      run_op("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 5'd1);
      run_op("mulhu", MULHU, 32'h8000_0000, 32'h8000_0000, 5'd2);
      run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd3);
      run_op("div", DIV, 32'hFFFF_FFF9, 32'd2, 5'd4);
      run_op("rem", REM, 32'hFFFF_FFF9, 32'd2, 5'd5);
      run_op("divu", DIVU, 32'd100, 32'd7, 5'd6);
      run_op("remu", REMU, 32'd100, 32'd7, 5'd7);
      run_op("divu0", DIVU, 32'd5, 32'd0, 5'd8);
      run_op("rem0", REM, 32'd5, 32'd0, 5'd9);
      run_op("divovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
      run_op("removf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
      run_op("divuovf", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
      // kill mid-operation, then restart in the cycle after the kill
      @(negedge clk);
      prev = result;
      issue(MUL, 32'd1234, 32'd5678, 5'd20, 1'b0, t0);
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill_busy", {31'b0, busy}, 32'h0);
      check("kill_result", result, prev);
      check("kill_tag", {27'b0, tag_out}, 32'd12);
      issue(DIVU, 32'd1000, 32'd9, 5'd21, 1'b1, n);
      wait_done("after_kill", t0, 44);
      // start held high through the whole operation, operands changing underneath
      @(negedge clk);
      funct3 = DIVU;
      a = 32'd1000;
      b = 32'd3;
      tag_in = 5'd13;
      start = 1'b1;
      t0 = cyc;
      exp_q.push_back({32'd333, 5'd13});
      n = 0;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
         if (n == 5) begin
            a = 32'd7;
            tag_in = 5'd1;
         end
      end
      check("hold_lat", 32'(cyc - t0), 32'd33);
      @(negedge clk);
      check("hold_idle", {31'b0, busy}, 32'h0);
      start = 1'b0;
      // start with kill while idle
      @(negedge clk);
      start = 1'b1;
      kill = 1'b1;
      @(negedge clk);
      start = 1'b0;
      kill = 1'b0;
      check("idle_kill_busy", {31'b0, busy}, 32'h0);
      repeat (3) @(negedge clk);
      check("idle_kill_busy2", {31'b0, busy}, 32'h0);
      // asynchronous reset between clock edges
      @(negedge clk);
      issue(MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd25, 1'b0, t0);
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_busy", {31'b0, busy}, 32'h0);
      check("arst_done", {31'b0, done}, 32'h0);
      check("arst_result", result, 32'h0);
      check("arst_tag", {27'b0, tag_out}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      run_op("post_rst", DIV, 32'hFFFF_FFF9, 32'd2, 5'd30);
      for (int i = 0; i < 16; i++) begin
         logic [2:0] f;
         logic [31:0] x, y;
         f = 3'($urandom_range(0, 7));
         x = $urandom;
         y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         run_op("rand", f, x, y, 5'($urandom_range(0, 31)));
      end
      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Iterative RV32M multiply/divide execution unit, parametrised in operand width. It gives the pipeline's MUL and DIV execution-unit codes a real multi-cycle implementation with a start/busy/done handshake and a result tag. It also accepts a kill input so that a taken branch can flush an in-flight operation. It sits beside the single-cycle ALU in EX. While it is busy, the pipeline stalls younger instructions.

## Interface
- XLEN, 32, operand/result width (≥ 8, even)
- TAGW, 5, width of destination-register tag carried through
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces all state to reset values immediately
- start  in  1  request; sampled only when busy=0
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand (dividend / multiplicand)
- b  in  XLEN  rs2 operand (divisor / multiplier)
- tag_in  in  TAGW  destination tag, captured with the operands
- kill  in  1  abort the in-flight operation (branch flush)
- busy  out  1  high in CALC and DONE states
- done  out  1  one-cycle pulse; result/tag_out valid in that cycle
- result  out  XLEN  registered result
- tag_out  out  TAGW  registered tag of the completed operation

## Operation
- States: IDLE, CALC, DONE.
- IDLE + start (and not kill):
  - latch funct3, tag_in, sign flags and operand magnitudes.
  - Fast-path cases go directly to DONE.
  - All other cases go to CALC with the iteration counter set to XLEN.
- Fast paths (DIV/DIVU/REM/REMU only):
  - b=0: quotient = all ones; remainder = a.
  - Signed overflow (DIV/REM with a=1<<(XLEN-1), b=all ones): quotient = a; remainder = 0.
- Multiply:
  - Unsigned shift-add on magnitudes, one multiplier bit per CALC cycle, into a 2·XLEN product.
  - Signedness: MUL and MULH treat both operands as signed. MULHSU treats a as signed and b as unsigned. MULHU treats both as unsigned.
  - If the signs differ, the product is negated once at the end.
  - MUL returns product[XLEN-1:0]. MULH/MULHSU/MULHU return product[2·XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes, one quotient bit per CALC cycle.
  - Quotient sign = sign(a) XOR sign(b), signed ops only.
  - Remainder sign = sign(a).
  - DIVU/REMU: no sign handling.
- CALC: decrement the counter each cycle. When the count reaches 0, apply the sign fix-up, register result and tag_out, and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- kill in any cycle where state≠IDLE:
  - next state is IDLE.
  - done is not asserted.
  - result and tag_out keep their previous values.
- kill has priority over start in the same cycle: start is ignored.
- kill in IDLE has no effect.
- start while busy=1 is ignored. This includes the DONE cycle. No queuing.
- result and tag_out change only when entering DONE. They hold their values otherwise.
- Reset values: state IDLE, busy 0, done 0, result 0, tag_out 0, counter 0.

## Timing
- start sampled at the end of cycle T.
- Normal operation:
  - busy=1 in cycles T+1 … T+XLEN+1.
  - done=1 in cycle T+XLEN+1.
  - busy=0 in cycle T+XLEN+2, so the next start can be sampled at the end of T+XLEN+2.
- Fast path: busy=1 and done=1 in cycle T+1; idle at T+2.
- Throughput: one operation per XLEN+2 cycles (normal) or per 2 cycles (fast path).
- kill asserted in cycle K: busy=0 in cycle K+1, and a start can be accepted at the end of K+1.
- Reset asserted mid-operation: outputs go to reset values without waiting for clk. After release, the unit is IDLE and accepts start on the next edge.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3), start at T:
  - done at T+33.
  - result=0xFFFFFFEB.
  - tag_out=tag_in.
  - busy low at T+34.
- MULH a=b=0x80000000 → result=0x40000000. MULHU with the same operands → result=0x40000000. MULHSU a=0xFFFFFFFF, b=2 → result=0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → result=0xFFFFFFFD. REM with the same operands → result=0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Fast paths:
  - DIVU a=5, b=0 → result=0xFFFFFFFF with done at T+1.
  - REM a=5, b=0 → result=5.
  - DIV a=0x80000000, b=0xFFFFFFFF → result=0x80000000.
  - REM with the same operands → result=0.
- Kill and start handling:
  - kill at T+10 → no done pulse, busy=0 at T+11, result unchanged.
  - New start at T+11 completes normally at T+44.
  - start held high while busy does not restart the operation.
  - start and kill in the same cycle while IDLE → ignored.
- Asynchronous reset asserted at T+5 between clock edges → busy, done, result, tag_out go to 0 immediately. The first start after release completes with the correct value.
